// File: rtl/bus_master_port_if.sv
// ============================================================================
//  Module   : bus_master_port_if
//  Purpose  : Bridge-side request/response and serial-bus signal bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface bus_master_port_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  dvalid;
   logic                  dmode;
   logic [ADDR_WIDTH-1:0] daddr;
   logic [DATA_WIDTH-1:0] dwdata;
   logic                  dready;
   logic [DATA_WIDTH-1:0] drdata;
   logic                  ddone;
   logic                  derr;
   logic                  mbreq;
   logic                  mbgrant;
   logic                  mmode;
   logic                  mvalid;
   logic                  mwdata;
   logic                  mack;
   logic                  svalid;
   logic                  mrdata;

   modport master (
      input  dvalid, dmode, daddr, dwdata, mbgrant, mack, svalid, mrdata,
      output dready, drdata, ddone, derr, mbreq, mmode, mvalid, mwdata
   );

   modport slave (
      output dvalid, dmode, daddr, dwdata, mbgrant, mack, svalid, mrdata,
      input  dready, drdata, ddone, derr, mbreq, mmode, mvalid, mwdata
   );
endinterface

`default_nettype wire

// File: rtl/bus_master_port.sv
// ============================================================================
//  Module   : bus_master_port
//  Purpose  : Serial-bus master: arbitrates, shifts out select/address/data,
//             collects read data and reports done or error to the bridge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bus_master_port #(
   parameter int ADDR_WIDTH     = 16,
   parameter int MEM_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int ACK_TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              rst,
   bus_master_port_if.master bus
);

   localparam int DEV_WIDTH = ADDR_WIDTH - MEM_ADDR_WIDTH;
   localparam int MAX_W     = (DEV_WIDTH > MEM_ADDR_WIDTH)
                            ? ((DEV_WIDTH > DATA_WIDTH) ? DEV_WIDTH : DATA_WIDTH)
                            : ((MEM_ADDR_WIDTH > DATA_WIDTH) ? MEM_ADDR_WIDTH : DATA_WIDTH);
   localparam int CNT_W     = $clog2(MAX_W) + 1;
   localparam int TO_W      = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_REQ      = 4'd1,
      S_SADDR    = 4'd2,
      S_WAIT_ACK = 4'd3,
      S_ADDR     = 4'd4,
      S_WDATA    = 4'd5,
      S_RDATA    = 4'd6,
      S_DONE     = 4'd7,
      S_ERR      = 4'd8
   } state_t;

   state_t                state_q, state_d;
   logic                  mode_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
   logic [CNT_W-1:0]      bit_q, bit_d;
   logic [TO_W-1:0]       to_q, to_d;

   logic                  dready, mbreq, mvalid, mwdata, ddone, derr;
   logic [DEV_WIDTH-1:0]      dev_sh;
   logic [MEM_ADDR_WIDTH-1:0] mem_sh;
   logic [DATA_WIDTH-1:0]     dat_sh;
   logic                  last_dev, last_mem, last_dat, timed_out;

   // Current serial bit is always bit 0 of the field shifted by the bit counter.
   assign dev_sh    = addr_q[ADDR_WIDTH-1:MEM_ADDR_WIDTH] >> bit_q;
   assign mem_sh    = addr_q[MEM_ADDR_WIDTH-1:0] >> bit_q;
   assign dat_sh    = wdata_q >> bit_q;
   assign last_dev  = (bit_q == CNT_W'(DEV_WIDTH - 1));
   assign last_mem  = (bit_q == CNT_W'(MEM_ADDR_WIDTH - 1));
   assign last_dat  = (bit_q == CNT_W'(DATA_WIDTH - 1));
   assign timed_out = (to_q == TO_W'(ACK_TIMEOUT));

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      to_d     = to_q;
      rx_d     = rx_q;
      drdata_d = drdata_q;
      dready   = 1'b0;
      mbreq    = 1'b0;
      mvalid   = 1'b0;
      mwdata   = 1'b0;
      ddone    = 1'b0;
      derr     = 1'b0;

      case (state_q)
         S_IDLE: begin
            dready = 1'b1;
            if (bus.dvalid) state_d = S_REQ;
         end
         S_REQ: begin
            mbreq = 1'b1;
            if (bus.mbgrant) state_d = S_SADDR;
         end
         S_SADDR: begin
            mbreq = 1'b1;
            if (!bus.mbgrant) begin
               state_d = S_ERR;
            end else begin
               mvalid = 1'b1;
               mwdata = dev_sh[0];
               bit_d  = bit_q + CNT_W'(1);
               if (last_dev) state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            mbreq = 1'b1;
            to_d  = to_q + TO_W'(1);
            if (!bus.mbgrant)  state_d = S_ERR;
            else if (bus.mack) state_d = S_ADDR;
            else if (timed_out) state_d = S_ERR;
         end
         S_ADDR: begin
            mbreq = 1'b1;
            if (!bus.mbgrant) begin
               state_d = S_ERR;
            end else begin
               mvalid = 1'b1;
               mwdata = mem_sh[0];
               bit_d  = bit_q + CNT_W'(1);
               if (last_mem) state_d = mode_q ? S_WDATA : S_RDATA;
            end
         end
         S_WDATA: begin
            mbreq = 1'b1;
            if (!bus.mbgrant) begin
               state_d = S_ERR;
            end else begin
               mvalid = 1'b1;
               mwdata = dat_sh[0];
               bit_d  = bit_q + CNT_W'(1);
               if (last_dat) state_d = S_DONE;
            end
         end
         S_RDATA: begin
            mbreq = 1'b1;
            to_d  = to_q + TO_W'(1);
            if (!bus.mbgrant) begin
               state_d = S_ERR;
            end else if (bus.svalid) begin
               rx_d  = rx_q | (DATA_WIDTH'(bus.mrdata) << bit_q);
               bit_d = bit_q + CNT_W'(1);
               to_d  = '0;
               if (last_dat) begin
                  state_d  = S_DONE;
                  drdata_d = rx_d;
               end
            end else if (timed_out) begin
               state_d = S_ERR;
            end
         end
         S_DONE: begin
            ddone   = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            derr    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Every state starts with fresh bit/timeout counters and an empty receive buffer.
      if (state_d != state_q) begin
         bit_d = '0;
         to_d  = '0;
         rx_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mode_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rx_q     <= '0;
         drdata_q <= '0;
         bit_q    <= '0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         rx_q     <= rx_d;
         drdata_q <= drdata_d;
         bit_q    <= bit_d;
         to_q     <= to_d;
         if (state_q == S_IDLE && bus.dvalid) begin
            mode_q  <= bus.dmode;
            addr_q  <= bus.daddr;
            wdata_q <= bus.dwdata;
         end
      end
   end

   assign bus.dready = dready;
   assign bus.drdata = drdata_q;
   assign bus.ddone  = ddone;
   assign bus.derr   = derr;
   assign bus.mbreq  = mbreq;
   assign bus.mmode  = mode_q & mbreq;
   assign bus.mvalid = mvalid;
   assign bus.mwdata = mwdata;

endmodule

`default_nettype wire

// File: tb/tb_bus_master_port.sv
// ============================================================================
//  Module   : tb_bus_master_port
//  Purpose  : Directed self-checking bench for bus_master_port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_master_port;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

   bus_master_port #(
      .ADDR_WIDTH(16), .MEM_ADDR_WIDTH(12), .DATA_WIDTH(8), .ACK_TIMEOUT(16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_req(input logic mode, input logic [15:0] addr, input logic [7:0] wd);
      bus.dvalid = 1'b1;
      bus.dmode  = mode;
      bus.daddr  = addr;
      bus.dwdata = wd;
      tick;
      bus.dvalid = 1'b0;
      bus.daddr  = '0;
      bus.dwdata = '0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      total++;
      if ({bus.dready, bus.ddone, bus.derr, bus.mbreq, bus.mvalid, bus.mwdata, bus.mmode} !== 7'b1000000) begin
         bad++;
         $display("FAIL rst_outputs got=%b exp=1000000", {bus.dready, bus.ddone, bus.derr, bus.mbreq, bus.mvalid, bus.mwdata, bus.mmode});
      end
      total++;
      if (bus.drdata !== 8'h00) begin
         bad++;
         $display("FAIL rst_drdata got=%h exp=00", bus.drdata);
      end
   endtask

   task automatic test_write;
      logic [23:0] got;
      int          nval;
      bit          early;
      got = '0; nval = 0; early = 0;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b1;
      start_req(1'b1, 16'h1A5C, 8'h3C);
      total++;
      if ({bus.dready, bus.mbreq, bus.mmode, bus.mvalid} !== 4'b0110) begin
         bad++;
         $display("FAIL wr_req_cycle got=%b exp=0110", {bus.dready, bus.mbreq, bus.mmode, bus.mvalid});
      end
      for (int c = 2; c <= 26; c++) begin
         tick;
         if (bus.ddone || bus.derr || bus.dready) early = 1;
         if (c == 6) begin
            total++;
            if (bus.mvalid !== 1'b0) begin
               bad++;
               $display("FAIL wr_wait_ack_mvalid got=%b exp=0", bus.mvalid);
            end
         end else if (bus.mvalid) begin
            got = {got[22:0], bus.mwdata};
            nval++;
         end
      end
      total++;
      if (got !== 24'b1000_0011_1010_0101_0011_1100) begin
         bad++;
         $display("FAIL wr_serial_stream got=%b exp=100000111010010100111100", got);
      end
      total++;
      if (nval != 24) begin
         bad++;
         $display("FAIL wr_mvalid_count got=%0d exp=24", nval);
      end
      total++;
      if (early) begin
         bad++;
         $display("FAIL wr_early_status got=1 exp=0");
      end
      tick;
      total++;
      if ({bus.ddone, bus.derr, bus.mbreq, bus.dready} !== 4'b1000) begin
         bad++;
         $display("FAIL wr_done_T27 got=%b exp=1000", {bus.ddone, bus.derr, bus.mbreq, bus.dready});
      end
      tick;
      total++;
      if ({bus.dready, bus.ddone} !== 2'b10) begin
         bad++;
         $display("FAIL wr_idle_T28 got=%b exp=10", {bus.dready, bus.ddone});
      end
   endtask

   task automatic test_read;
      logic [7:0] bits;
      bit         mv_bad;
      bit         early;
      bits = 8'h96; mv_bad = 0; early = 0;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b1;
      start_req(1'b0, 16'h0012, 8'hFF);
      total++;
      if ({bus.mbreq, bus.mmode} !== 2'b10) begin
         bad++;
         $display("FAIL rd_req_mode got=%b exp=10", {bus.mbreq, bus.mmode});
      end
      for (int c = 2; c <= 19; c++) tick;
      for (int i = 0; i < 8; i++) begin
         bus.svalid = 1'b1;
         bus.mrdata = bits[i];
         #1;
         if (bus.mvalid !== 1'b0 || bus.mwdata !== 1'b0) mv_bad = 1;
         if (bus.ddone || bus.derr) early = 1;
         tick;
         bus.svalid = 1'b0;
         bus.mrdata = 1'b0;
         if (i < 7) begin
            if (bus.mvalid !== 1'b0) mv_bad = 1;
            if (bus.ddone || bus.derr) early = 1;
            tick;
         end
      end
      total++;
      if ({bus.ddone, bus.derr} !== 2'b10) begin
         bad++;
         $display("FAIL rd_done_pulse got=%b exp=10", {bus.ddone, bus.derr});
      end
      total++;
      if (bus.drdata !== 8'h96) begin
         bad++;
         $display("FAIL rd_data got=%h exp=96", bus.drdata);
      end
      total++;
      if (mv_bad || early) begin
         bad++;
         $display("FAIL rd_rdata_phase got=mvalid_bad:%0d early:%0d exp=0,0", mv_bad, early);
      end
      tick;
      total++;
      if ({bus.dready, bus.ddone, bus.drdata} !== {2'b10, 8'h96}) begin
         bad++;
         $display("FAIL rd_hold got=%b/%h exp=10/96", {bus.dready, bus.ddone}, bus.drdata);
      end
   endtask

   task automatic test_timeout;
      bit early;
      early = 0;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b0;
      start_req(1'b1, 16'h3456, 8'h55);
      for (int c = 2; c <= 22; c++) begin
         tick;
         if (bus.derr || bus.ddone) early = 1;
      end
      total++;
      if (early || bus.mbreq !== 1'b1) begin
         bad++;
         $display("FAIL to_before_expiry got=early:%0d mbreq:%b exp=0,1", early, bus.mbreq);
      end
      tick;
      total++;
      if ({bus.derr, bus.ddone, bus.mbreq} !== 3'b100) begin
         bad++;
         $display("FAIL to_derr_T23 got=%b exp=100", {bus.derr, bus.ddone, bus.mbreq});
      end
      total++;
      if (bus.drdata !== 8'h96) begin
         bad++;
         $display("FAIL to_drdata_kept got=%h exp=96", bus.drdata);
      end
      tick;
      total++;
      if ({bus.dready, bus.derr} !== 2'b10) begin
         bad++;
         $display("FAIL to_back_idle got=%b exp=10", {bus.dready, bus.derr});
      end
      bus.mack = 1'b1;
   endtask

   task automatic test_ack_last;
      bit seen_err;
      seen_err = 0;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b0;
      start_req(1'b1, 16'h1A5C, 8'h3C);
      for (int c = 2; c <= 22; c++) tick;
      bus.mack = 1'b1;
      tick;
      total++;
      if ({bus.mvalid, bus.derr} !== 2'b10) begin
         bad++;
         $display("FAIL ack_last_cycle got=%b exp=10", {bus.mvalid, bus.derr});
      end
      for (int c = 24; c <= 43; c++) begin
         tick;
         if (bus.derr) seen_err = 1;
      end
      total++;
      if (bus.ddone !== 1'b1 || seen_err) begin
         bad++;
         $display("FAIL ack_last_done got=ddone:%b err:%0d exp=1,0", bus.ddone, seen_err);
      end
      tick;
   endtask

   task automatic test_grant_loss;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b1;
      start_req(1'b1, 16'h2FFF, 8'hA5);
      for (int c = 2; c <= 12; c++) tick;
      total++;
      if ({bus.mvalid, bus.mwdata} !== 2'b11) begin
         bad++;
         $display("FAIL gl_addr_bit5 got=%b exp=11", {bus.mvalid, bus.mwdata});
      end
      bus.mbgrant = 1'b0;
      #1;
      total++;
      if ({bus.mvalid, bus.mwdata} !== 2'b00) begin
         bad++;
         $display("FAIL gl_serial_drop got=%b exp=00", {bus.mvalid, bus.mwdata});
      end
      tick;
      total++;
      if ({bus.derr, bus.ddone, bus.mbreq, bus.mvalid} !== 4'b1000) begin
         bad++;
         $display("FAIL gl_derr got=%b exp=1000", {bus.derr, bus.ddone, bus.mbreq, bus.mvalid});
      end
      bus.mbgrant = 1'b1;
      tick;
      total++;
      if ({bus.dready, bus.derr, bus.ddone} !== 3'b100) begin
         bad++;
         $display("FAIL gl_back_idle got=%b exp=100", {bus.dready, bus.derr, bus.ddone});
      end
   endtask

   task automatic test_reset_mid;
      int n;
      n = 0;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b1;
      start_req(1'b1, 16'h1A5C, 8'h3C);
      for (int c = 2; c <= 20; c++) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      total++;
      if ({bus.dready, bus.ddone, bus.derr, bus.mbreq, bus.mvalid, bus.mwdata, bus.mmode, bus.drdata} !== {7'b1000000, 8'h00}) begin
         bad++;
         $display("FAIL rm_reset_state got=%b/%h exp=1000000/00",
                  {bus.dready, bus.ddone, bus.derr, bus.mbreq, bus.mvalid, bus.mwdata, bus.mmode}, bus.drdata);
      end
      bus.dvalid = 1'b1;
      bus.dmode  = 1'b1;
      bus.daddr  = 16'h1A5C;
      bus.dwdata = 8'h3C;
      for (int k = 1; k <= 60; k++) begin
         tick;
         bus.dvalid = 1'b0;
         if (bus.ddone) begin
            n = k;
            break;
         end
      end
      total++;
      if (n != 27) begin
         bad++;
         $display("FAIL rm_followup_latency got=%0d exp=27", n);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      int nacc, acc2, nd, d1, d2;
      nacc = 0; acc2 = -1; nd = 0; d1 = -1; d2 = -1;
      bus.mbgrant = 1'b1;
      bus.mack    = 1'b1;
      bus.dvalid  = 1'b1;
      bus.dmode   = 1'b1;
      bus.daddr   = 16'h5123;
      bus.dwdata  = 8'h81;
      for (int c = 0; c <= 60; c++) begin
         if (bus.dready) begin
            nacc++;
            if (nacc == 2) acc2 = c;
         end
         if (bus.ddone) begin
            nd++;
            if (nd == 1) d1 = c;
            else if (nd == 2) d2 = c;
         end
         tick;
      end
      bus.dvalid = 1'b0;
      total++;
      if (nacc != 3 || acc2 != 28) begin
         bad++;
         $display("FAIL b2b_accepts got=%0d@%0d exp=3@28", nacc, acc2);
      end
      total++;
      if (nd != 2 || d1 != 27 || d2 != 55) begin
         bad++;
         $display("FAIL b2b_done got=%0d:%0d,%0d exp=2:27,55", nd, d1, d2);
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      bus.dvalid  = 1'b0;
      bus.dmode   = 1'b0;
      bus.daddr   = '0;
      bus.dwdata  = '0;
      bus.mbgrant = 1'b0;
      bus.mack    = 1'b0;
      bus.svalid  = 1'b0;
      bus.mrdata  = 1'b0;
      test_reset;
      test_write;
      test_read;
      test_timeout;
      test_ack_last;
      test_grant_loss;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
